// File: rtl/vga_pkg.sv
// vga_pkg: shared timing helpers, 640x480@60 defaults and the control-bit
// bundle that travels down the sync delay line.
package vga_pkg;

    // Line/frame arithmetic shared by the generator and any neighbour that
    // needs to know where sync sits.
    function automatic int unsigned vga_total(input int unsigned act, fp, sync, bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned vga_sync_start(input int unsigned act, fp);
        return act + fp;
    endfunction

    function automatic int unsigned vga_sync_end(input int unsigned act, fp, sync);
        return act + fp + sync;
    endfunction

    // 640x480@60 Hz defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL    = vga_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL    = vga_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int unsigned DEF_HS_START   = vga_sync_start(DEF_H_ACTIVE, DEF_H_FP);
    localparam int unsigned DEF_HS_END     = vga_sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
    localparam int unsigned DEF_VS_START   = vga_sync_start(DEF_V_ACTIVE, DEF_V_FP);
    localparam int unsigned DEF_VS_END     = vga_sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
    } vga_ctrl_t;

    // Inactive level: both syncs high, picture blanked.
    localparam vga_ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: coordinate/sync bundle from the timing generator to the
// colour stage and DAC. frame_cnt exists only with VGA_FRAME_CNT_EN defined.
interface vga_timing_gen_if;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pix_en;
    logic        vga_clk;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        sync_n;
    logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    modport master (output x, y, pix_en, vga_clk, hsync, vsync, blank_n, sync_n,
                           frame_start, frame_cnt);
    modport slave  (input  x, y, pix_en, vga_clk, hsync, vsync, blank_n, sync_n,
                           frame_start, frame_cnt);
`else
    modport master (output x, y, pix_en, vga_clk, hsync, vsync, blank_n, sync_n,
                           frame_start);
    modport slave  (input  x, y, pix_en, vga_clk, hsync, vsync, blank_n, sync_n,
                           frame_start);
`endif
endinterface

// File: rtl/sync_delay.sv
// sync_delay: DEPTH-stage shift register of vga_ctrl_t, advancing only on en.
// DEPTH=0 is a plain wire so the caller can match any colour-stage latency.
module sync_delay
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 1
)(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  vga_ctrl_t din,
    output vga_ctrl_t dout
);

    if (DEPTH == 0) begin : g_thru
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, en};
        assign dout      = din;
    end else begin : g_pipe
        vga_ctrl_t [DEPTH-1:0] stg;

        // Shift one stage per pixel tick; reset to inactive levels.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg <= {DEPTH{CTRL_IDLE}};
            end else if (en) begin
                stg[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) stg[i] <= stg[i-1];
            end
        end

        assign dout = stg[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel divider, x/y counters, sync/blank decode and
// aligned delay line. Optional frame counter under VGA_FRAME_CNT_EN.
// Synthesis note: with CLK_DIV=1 vga_clk is tied low (no ~clk output); the
// DAC must then be clocked from clk directly.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned PIPE_DLY = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = vga_sync_start(H_ACTIVE, H_FP);
    localparam int unsigned HS_END   = vga_sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int unsigned VS_START = vga_sync_start(V_ACTIVE, V_FP);
    localparam int unsigned VS_END   = vga_sync_end(V_ACTIVE, V_FP, V_SYNC);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [1:0] DIV_HALF = 2'(CLK_DIV / 2);

    if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be < 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be 1..4");
    end
    if (PIPE_DLY > 3) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..3");
    end

    logic [1:0] div, div_nxt;
    logic [9:0] x_q, y_q, x_nxt, y_nxt;
    logic       pix_en_q, vga_clk_q, fs_q;
    vga_ctrl_t  raw_nxt, ctrl_q, ctrl_dly;

    // Next divider/counter values and decode of the position about to be shown.
    always_comb begin
        div_nxt = (div == DIV_LAST) ? 2'd0 : div + 2'd1;
        x_nxt   = x_q;
        y_nxt   = y_q;
        if (pix_en_q) begin
            if (x_q == 10'(H_TOTAL - 1)) begin
                x_nxt = '0;
                y_nxt = (y_q == 10'(V_TOTAL - 1)) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_nxt = x_q + 10'd1;
            end
        end
        raw_nxt.hsync   = !(x_nxt >= 10'(HS_START) && x_nxt < 10'(HS_END));
        raw_nxt.vsync   = !(y_nxt >= 10'(VS_START) && y_nxt < 10'(VS_END));
        raw_nxt.blank_n = (x_nxt < 10'(H_ACTIVE)) && (y_nxt < 10'(V_ACTIVE));
    end

    // Divider, strobes, counters and the zero-delay control register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            fs_q      <= 1'b0;
            ctrl_q    <= CTRL_IDLE;
        end else begin
            div       <= div_nxt;
            pix_en_q  <= (div_nxt == DIV_LAST);
            vga_clk_q <= (div_nxt >= DIV_HALF);
            x_q       <= x_nxt;
            y_q       <= y_nxt;
            fs_q      <= pix_en_q && (x_nxt == 10'd0) && (y_nxt == 10'd0);
            if (pix_en_q) ctrl_q <= raw_nxt;
        end
    end

    sync_delay #(.DEPTH(PIPE_DLY)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en_q),
        .din   (ctrl_q),
        .dout  (ctrl_dly)
    );

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    frame_cnt_q <= '0;
        else if (fs_q) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.pix_en      = pix_en_q;
    assign vga.vga_clk     = (CLK_DIV == 1) ? 1'b0 : vga_clk_q;
    assign vga.hsync       = ctrl_dly.hsync;
    assign vga.vsync       = ctrl_dly.vsync;
    assign vga.blank_n     = ctrl_dly.blank_n;
    assign vga.sync_n      = 1'b0;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator instances (different CLK_DIV/PIPE_DLY,
// shrunk raster) checked every clk against an arithmetic reference model,
// with randomly placed asynchronous resets.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n = 0;        // clk edges since reset release
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if ia();
    vga_timing_gen_if ib();
    vga_timing_gen_if ic();

    vga_timing_gen #(.CLK_DIV(2), .PIPE_DLY(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
        u_a (.clk(clk), .rst_n(rst_n), .vga(ia));
    vga_timing_gen #(.CLK_DIV(3), .PIPE_DLY(3), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
        u_b (.clk(clk), .rst_n(rst_n), .vga(ib));
    vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(0), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
        u_c (.clk(clk), .rst_n(rst_n), .vga(ic));

    task automatic chk(string tag, int unsigned got, int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    // Pixel ticks taken after e clk edges since release.
    function automatic int ticks(int d, int e);
        if (d == 1) return (e > 0) ? e - 1 : 0;
        return e / d;
    endfunction

    task automatic chk_inst(string nm, int d, int dly, logic [9:0] x, logic [9:0] y,
                            logic pe, logic vc, logic hs, logic vs, logic bl,
                            logic fs, logic [15:0] cnt);
        int   k, kp, kd, px, py;
        logic e_hs, e_vs, e_bl;
        k    = ticks(d, n);
        kp   = (n > 0) ? ticks(d, n - 1) : 0;
        e_hs = 1'b1;
        e_vs = 1'b1;
        e_bl = 1'b0;
        if (k > dly) begin
            kd   = k - dly;
            px   = kd % HT;
            py   = (kd / HT) % VT;
            e_hs = !(px >= HA + HF && px < HA + HF + HS);
            e_vs = !(py >= VA + VF && py < VA + VF + VS);
            e_bl = (px < HA) && (py < VA);
        end
        chk({nm, ".x"},       x,  k % HT);
        chk({nm, ".y"},       y,  (k / HT) % VT);
        chk({nm, ".pix_en"},  pe, (n >= 1 && n % d == d - 1) ? 1 : 0);
        chk({nm, ".vga_clk"}, vc, (d > 1 && n % d >= d / 2) ? 1 : 0);
        chk({nm, ".hsync"},   hs, e_hs);
        chk({nm, ".vsync"},   vs, e_vs);
        chk({nm, ".blank_n"}, bl, e_bl);
        chk({nm, ".fstart"},  fs, (k != kp && k % FR == 0) ? 1 : 0);
`ifdef VGA_FRAME_CNT_EN
        chk({nm, ".fcnt"},    cnt, (kp / FR) % 65536);
`else
        if (cnt != 16'h0) $display("note: unexpected cnt arg");
`endif
    endtask

    task automatic check_all();
        logic [15:0] ca, cb, cc;
        ca = '0; cb = '0; cc = '0;
`ifdef VGA_FRAME_CNT_EN
        ca = ia.frame_cnt; cb = ib.frame_cnt; cc = ic.frame_cnt;
`endif
        chk_inst("a", 2, 1, ia.x, ia.y, ia.pix_en, ia.vga_clk, ia.hsync, ia.vsync, ia.blank_n, ia.frame_start, ca);
        chk_inst("b", 3, 3, ib.x, ib.y, ib.pix_en, ib.vga_clk, ib.hsync, ib.vsync, ib.blank_n, ib.frame_start, cb);
        chk_inst("c", 1, 0, ic.x, ic.y, ic.pix_en, ic.vga_clk, ic.hsync, ic.vsync, ic.blank_n, ic.frame_start, cc);
        chk("a.sync_n", ia.sync_n, 0);
    endtask

    int bl_cnt, vs_lo, hs_lo;

    // Run c clk cycles, sampling on the falling edge; tally instance a's
    // per-tick sync/blank over its second frame.
    task automatic run(int c);
        int k;
        repeat (c) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check_all();
            k = ticks(2, n);
            if (ia.pix_en && k >= FR && k < 2 * FR) begin
                if (ia.blank_n) bl_cnt++;
                if (!ia.vsync)  vs_lo++;
                if (!ia.hsync && k < FR + HT) hs_lo++;
            end
        end
    endtask

    initial begin
        bl_cnt = 0; vs_lo = 0; hs_lo = 0;
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        run(2 * FR * 3 + 200);
        chk("a.blank_ticks",  bl_cnt, HA * VA);
        chk("a.vsync_ticks",  vs_lo,  VS * HT);
        chk("a.hsync_ticks",  hs_lo,  HS);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            #2 rst_n = 1'b0;
            n = 0;
            #1 check_all();
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check_all();
            end
            rst_n = 1'b1;
            run($urandom_range(100, 1500));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream neighbour of the pixel/colour generator. Produces the pixel coordinates the colour stage uses to address image RAM.
- Produces 640x480@60 Hz VGA sync, blank and DAC clock signals.
- Sync and blank are delayed to line up with the colour stage's synchronous-RAM read latency, so r/g/b, hsync, vsync and blank_n reach the DAC aligned.

Parameters:
- CLK_DIV, 2, system clocks per pixel; 50 MHz in gives 25 MHz pixel rate; legal values 1..4.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- PIPE_DLY, 1, pixel ticks by which hsync/vsync/blank_n lag x/y; legal values 0..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- x  out  10  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- pix_en  out  1  one-clk strobe; x/y advance on the clk edge where it is 1
- vga_clk  out  1  DAC pixel clock; rising edge mid-pixel
- hsync  out  1  active-low horizontal sync, delayed by PIPE_DLY
- vsync  out  1  active-low vertical sync, delayed by PIPE_DLY
- blank_n  out  1  1 inside the active area, delayed by PIPE_DLY
- sync_n  out  1  constant 0 (no sync-on-green)
- frame_start  out  1  one-clk pulse when x=0,y=0 is first presented
- [VGA_FRAME_CNT_EN only] frame_cnt  out  16  completed-frame counter

Behaviour:
- Clocking: one clock domain, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: x=0, y=0, div counter=0, pix_en=0, vga_clk=0, hsync=1, vsync=1, blank_n=0, frame_start=0, all delay-line stages at their inactive values, frame_cnt=0.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and equals 1 during the clk cycle in which div==CLK_DIV-1.
  - With CLK_DIV=1, pix_en is held at 1 after reset release.
- vga_clk:
  - Equals 1 while div >= CLK_DIV/2 (registered).
  - With CLK_DIV=1, vga_clk = ~clk is forbidden; tie vga_clk to 0 and flag it in synthesis notes.
- Counters (update only on clk edges with pix_en=1):
  - x increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, y increments and wraps V_TOTAL-1 -> 0.
  - x and y are never out of range.
- Raw, undelayed decodes:
  - h_act = x < H_ACTIVE; v_act = y < V_ACTIVE.
  - hs_raw = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
  - blank_raw_n = h_act & v_act.
- Delay line:
  - PIPE_DLY stages; each stage shifts only on pix_en.
  - Outputs equal the raw values PIPE_DLY pixel ticks earlier.
  - PIPE_DLY=0 means the outputs are the raw decodes registered in the same cycle as x/y.
- frame_start: asserted for the single clk cycle after the edge that moves (x,y) to (0,0); not delayed.
- Reset mid-frame: all state returns to reset values immediately. The first frame after release starts at (0,0), with frame_start pulsing after the first full line-wrap sequence completes.
- Arithmetic: comparisons are 10-bit unsigned; parameter sums must be < 1024 (checked by elaboration-time assertion).

Optional Feature:
- VGA_FRAME_CNT_EN defined:
  - frame_cnt port exists.
  - frame_cnt increments on each frame_start pulse and wraps 0xFFFF -> 0.
  - Used by the processor for frame pacing.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - timing localparams (H_TOTAL, V_TOTAL, sync start/end) as functions of the parameters;
  - 640x480 defaults;
  - a typedef struct {hsync, vsync, blank_n} vga_ctrl_t for the delay line.
- Sub-module sync_delay: a PIPE_DLY-deep shift register of vga_ctrl_t with shift enable. It is reusable if the colour stage latency changes.

Test Plan:
- Reset release with CLK_DIV=2 -> pix_en toggles every 2 clk; x goes 0,1,2 on successive pix_en edges; vga_clk has 50% duty.
- Run one line -> x wraps 799->0 and y increments 0->1 on the same edge. With PIPE_DLY=1, hsync is low for exactly 96 pixel ticks, starting one tick after x=656.
- Run one frame -> vsync is low for 2 lines at y=490..491 (+1 tick). blank_n has exactly 640*480 high pixel ticks, and frame_start pulses once, after y wraps 524->0.
- Assert rst_n=0 at x=300,y=200 for 3 clk -> x=y=0, hsync=vsync=1, blank_n=0 asynchronously. After release, counting restarts from 0.
- PIPE_DLY=0 vs 3 -> blank_n falls at the tick after x=639 vs 3 ticks later; x/y timing is unchanged.
- With VGA_FRAME_CNT_EN, run 3 frames -> frame_cnt=3. Preload via force to 0xFFFF, one frame -> 0.
